// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM state codes, opcodes,
// ALU operation codes and datapath mux select values.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    // Which operation class the ALU decoder should resolve.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_RTYPE = 2'd2,
        ALUOP_ITYPE = 2'd3
    } aluop_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format depends only on the opcode, so it is valid in every state.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] imm;
        case (op)
            OP_SW:   imm = IMM_S;
            OP_BEQ:  imm = IMM_B;
            OP_JAL:  imm = IMM_J;
            default: imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the operation class plus funct fields to an ALU operation code and flags
// funct3 values the core does not implement.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  aluop_t      aluop,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    output logic [2:0]  alu_control,
    output logic        bad_funct
);

    always_comb begin
        alu_control = ALU_ADD;
        bad_funct   = 1'b0;
        case (aluop)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_RTYPE, ALUOP_ITYPE: begin
                case (funct3)
                    // funct7b5 selects sub only for register-register ops; on addi it is immediate data.
                    F3_ADD:  alu_control = (aluop == ALUOP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
                    F3_SLT:  alu_control = ALU_SLT;
                    F3_OR:   alu_control = ALU_OR;
                    F3_AND:  alu_control = ALU_AND;
                    default: bad_funct   = 1'b1;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the non-pipelined RV32I core: one FSM state per cycle,
// driving all datapath enables and mux selects, plus a retired-instruction counter.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter int unsigned RETIRE_W      = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          op,
    input  logic [2:0]          funct3,
    input  logic                funct7b5,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                AdrSrc,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                RegWrite,
    output logic [1:0]          ResultSrc,
    output logic [1:0]          ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ImmSrc,
    output logic [2:0]          ALUControl,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retire_cnt,
    output logic [3:0]          state_o
);

    state_t              state_q, state_d;
    logic [RETIRE_W-1:0] retire_q, retire_d;

    logic   mem_rdy;
    aluop_t aluop;
    logic   bad_funct;
    logic   retire;
    logic   pc_write, mem_write, ir_write, reg_write;

    assign mem_rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

    always_comb begin
        case (state_q)
            S_EXECR: aluop = ALUOP_RTYPE;
            S_EXECI: aluop = ALUOP_ITYPE;
            S_BEQ:   aluop = ALUOP_SUB;
            default: aluop = ALUOP_ADD;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop       (aluop),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .alu_control (ALUControl),
        .bad_funct   (bad_funct)
    );

    always_comb begin
        state_d   = state_q;
        pc_write  = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        retire    = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                ir_write  = mem_rdy;
                pc_write  = mem_rdy;
                if (mem_rdy) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Precompute the branch/jump target into ALUOut while the opcode is resolved.
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECR;
                    OP_ITYPE:     state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_rdy) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
                if (mem_rdy) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                state_d = bad_funct ? S_ILLEGAL : S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                state_d = bad_funct ? S_ILLEGAL : S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BEQ: begin
                // ALUOut still holds the target computed in DECODE; the ALU compares rs1/rs2.
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_RS2;
                ResultSrc = RES_ALUOUT;
                pc_write  = zero;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALUOUT;
                pc_write  = 1'b1;
                state_d   = S_ALUWB;
            end
            S_ILLEGAL: begin
                state_d = S_ILLEGAL;
            end
            default: begin
                state_d = S_ILLEGAL;
            end
        endcase
    end

    always_comb begin
        retire_d = retire_q;
        if (retire) begin
            retire_d = retire_q + RETIRE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_FETCH;
            retire_q <= '0;
        end else begin
            state_q  <= state_d;
            retire_q <= retire_d;
        end
    end

    // Enables are masked by rst directly so they fall in the same cycle reset is asserted.
    assign PCWrite    = pc_write  & ~rst;
    assign MemWrite   = mem_write & ~rst;
    assign IRWrite    = ir_write  & ~rst;
    assign RegWrite   = reg_write & ~rst;
    assign ImmSrc     = imm_src_of(op);
    assign illegal    = (state_q == S_ILLEGAL);
    assign retire_cnt = retire_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each stimulus cycle queues its expected outputs,
// and a negedge monitor pops and compares them against the DUT.
module tb_multicycle_ctrl;

    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3;
    localparam logic [3:0] MEMWB = 4'd4, MEMWRITE = 4'd5, EXECR = 4'd6, EXECI = 4'd7;
    localparam logic [3:0] ALUWB = 4'd8, BEQ = 4'd9, JAL = 4'd10, ILLEGAL = 4'd11;

    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111;

    localparam logic [2:0] A_ADD = 3'b000, A_SUB = 3'b001, A_AND = 3'b010;
    localparam logic [2:0] A_OR = 3'b011, A_SLT = 3'b101;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;

    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] retire_cnt;
    logic [3:0] state_o;

    multicycle_ctrl #(.MEM_HANDSHAKE(1'b1), .RETIRE_W(4)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .illegal(illegal),
        .retire_cnt(retire_cnt), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [24:0] vec;
        bit          alu_dc;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         failures = 0;
    logic [3:0] exp_cnt = 4'd0;

    // Layout: {state,PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,illegal,retire_cnt}
    function automatic logic [24:0] expect_vec(input logic [3:0] st, input logic [2:0] alu_arg);
        logic [3:0] s;
        logic       pcw, adr, mw, irw, rw, ill;
        logic [1:0] rs, sa, sb, imm;
        logic [2:0] alu;
        logic [3:0] cnt;
        s = rst ? FETCH : st;
        {pcw, adr, mw, irw, rw, ill} = 6'b0;
        rs = 2'b00; sa = 2'b00; sb = 2'b00; alu = A_ADD;
        case (op)
            OP_SW:   imm = 2'b01;
            OP_BEQ:  imm = 2'b10;
            OP_JAL:  imm = 2'b11;
            default: imm = 2'b00;
        endcase
        case (s)
            FETCH:    begin sb = 2'b10; rs = 2'b10; irw = mem_ready; pcw = mem_ready; end
            DECODE:   begin sa = 2'b01; sb = 2'b01; end
            MEMADR:   begin sa = 2'b10; sb = 2'b01; end
            MEMREAD:  adr = 1'b1;
            MEMWB:    begin rs = 2'b01; rw = 1'b1; end
            MEMWRITE: begin adr = 1'b1; mw = 1'b1; end
            EXECR:    begin sa = 2'b10; sb = 2'b00; alu = alu_arg; end
            EXECI:    begin sa = 2'b10; sb = 2'b01; alu = alu_arg; end
            ALUWB:    rw = 1'b1;
            BEQ:      begin sa = 2'b10; alu = A_SUB; pcw = zero; end
            JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
            ILLEGAL:  ill = 1'b1;
            default:  ;
        endcase
        if (rst) begin
            {pcw, mw, irw, rw} = 4'b0;
        end
        cnt = rst ? 4'd0 : exp_cnt;
        return {s, pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ill, cnt};
    endfunction

    // Queue the expectation for the current cycle, then advance one clock.
    task automatic step(input string tag, input logic [3:0] st, input logic [2:0] alu, input bit dc = 1'b0);
        exp_t e;
        e.tag    = tag;
        e.vec    = expect_vec(st, alu);
        e.alu_dc = dc;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (!rst && (st == MEMWB || (st == MEMWRITE && mem_ready) || st == ALUWB || st == BEQ)) begin
            exp_cnt = exp_cnt + 4'd1;
        end
    endtask

    task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o;
        funct3 = f3;
        funct7b5 = f7;
    endtask

    task automatic fetch_decode(input string tag);
        step({tag, "_fetch"}, FETCH, A_ADD);
        step({tag, "_decode"}, DECODE, A_ADD);
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [24:0] act;
        logic [24:0] mask;
        if (q.size() > 0) begin
            e = q.pop_front();
            act = {state_o, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                   ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal, retire_cnt};
            mask = e.alu_dc ? 25'h1FFFF1F : 25'h1FFFFFF;
            checks++;
            if (((act ^ e.vec) & mask) != 25'd0) begin
                failures++;
                $display("FAIL %s: got %b required %b", e.tag, act, e.vec);
            end else begin
                $display("ok   %s: %b", e.tag, act);
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        rst = 1'b1;
        step("reset0", FETCH, A_ADD);
        step("reset1", FETCH, A_ADD);
        rst = 1'b0;

        instr(OP_I, 3'b000, 1'b0);
        fetch_decode("addi");
        step("addi_exec", EXECI, A_ADD);
        step("addi_wb", ALUWB, A_ADD);

        instr(OP_I, 3'b000, 1'b1);
        fetch_decode("addi_f7");
        step("addi_f7_exec", EXECI, A_ADD);
        step("addi_f7_wb", ALUWB, A_ADD);

        instr(OP_R, 3'b000, 1'b1);
        fetch_decode("sub");
        step("sub_exec", EXECR, A_SUB);
        step("sub_wb", ALUWB, A_ADD);

        instr(OP_R, 3'b111, 1'b0);
        fetch_decode("and");
        step("and_exec", EXECR, A_AND);
        step("and_wb", ALUWB, A_ADD);

        instr(OP_I, 3'b110, 1'b0);
        fetch_decode("ori");
        step("ori_exec", EXECI, A_OR);
        step("ori_wb", ALUWB, A_ADD);

        instr(OP_R, 3'b010, 1'b0);
        fetch_decode("slt");
        step("slt_exec", EXECR, A_SLT);
        step("slt_wb", ALUWB, A_ADD);

        instr(OP_LW, 3'b010, 1'b0);
        mem_ready = 1'b0;
        step("lw_fetch_wait", FETCH, A_ADD);
        mem_ready = 1'b1;
        fetch_decode("lw");
        step("lw_memadr", MEMADR, A_ADD);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("lw_memread_wait", MEMREAD, A_ADD);
        mem_ready = 1'b1;
        step("lw_memread_done", MEMREAD, A_ADD);
        step("lw_memwb", MEMWB, A_ADD);

        instr(OP_SW, 3'b010, 1'b0);
        fetch_decode("sw");
        step("sw_memadr", MEMADR, A_ADD);
        mem_ready = 1'b0;
        step("sw_memwrite_wait", MEMWRITE, A_ADD);
        mem_ready = 1'b1;
        step("sw_memwrite_done", MEMWRITE, A_ADD);

        instr(OP_BEQ, 3'b000, 1'b0);
        zero = 1'b1;
        fetch_decode("beq_taken");
        step("beq_taken", BEQ, A_SUB);
        zero = 1'b0;
        fetch_decode("beq_not");
        step("beq_not", BEQ, A_SUB);

        instr(OP_JAL, 3'b000, 1'b0);
        fetch_decode("jal");
        step("jal_exec", JAL, A_ADD);
        step("jal_wb", ALUWB, A_ADD);

        instr(OP_BEQ, 3'b000, 1'b0);
        for (int i = 0; i < 16; i++) begin
            zero = i[0];
            fetch_decode("wrap_beq");
            step("wrap_beq", BEQ, A_SUB);
        end
        zero = 1'b0;

        instr(OP_SW, 3'b010, 1'b0);
        fetch_decode("sw_rst");
        step("sw_rst_memadr", MEMADR, A_ADD);
        mem_ready = 1'b0;
        step("sw_rst_memwrite", MEMWRITE, A_ADD);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (MemWrite !== 1'b0 || state_o !== FETCH) begin
            failures++;
            $display("FAIL async_rst_drop: MemWrite=%b state=%0d required MemWrite=0 state=0", MemWrite, state_o);
        end
        exp_cnt = 4'd0;
        step("rst_mid_sw", FETCH, A_ADD);
        rst = 1'b0;
        mem_ready = 1'b1;

        instr(OP_R, 3'b001, 1'b0);
        fetch_decode("bad_f3");
        step("bad_f3_exec", EXECR, A_ADD, 1'b1);
        for (int i = 0; i < 3; i++) step("bad_f3_trap", ILLEGAL, A_ADD);
        rst = 1'b1;
        exp_cnt = 4'd0;
        step("rst_after_bad_f3", FETCH, A_ADD);
        rst = 1'b0;

        instr(7'h7F, 3'b000, 1'b0);
        fetch_decode("op7f");
        for (int i = 0; i < 100; i++) begin
            mem_ready = i[0];
            step("op7f_trap", ILLEGAL, A_ADD);
        end
        mem_ready = 1'b1;
        rst = 1'b1;
        exp_cnt = 4'd0;
        step("rst_after_trap", FETCH, A_ADD);
        rst = 1'b0;
        step("fetch_after_trap", FETCH, A_ADD);

        for (int i = 0; i < 8 && q.size() > 0; i++) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: pending=%0d required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
